shift_right_seq: RTL

- Iterative right shifter for the datapath. Counterpart of the combinational left-by-2 shifter.
- Recovers word indices from byte offsets (in >> 2) and executes srl/sra by a variable shamt.
- Shifts one bit per clock under a start/done handshake. Used by the multi-cycle execute path and by address-decode logic that can tolerate latency.

---
 rtl/shift_right_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/shift_right_seq.sv
// shift_right_seq: iterative right shifter, one bit per clock.
// Logical or arithmetic shift under a start/done handshake.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   start    : request, sampled only while idle
//   in_data  : operand, captured on an accepted start
//   shamt    : shift amount, captured with in_data
//   arith    : 1 = sign fill, 0 = zero fill; captured with in_data
//   busy     : high whenever not idle (DONE included)
//   done     : one-cycle pulse when out_data is updated
//   out_data : result, held until the next operation completes
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               arith_q, arith_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic               fill;
  logic [WIDTH-1:0]   shifted;

  assign fill    = arith_q & sr_q[WIDTH-1];
  assign shifted = {fill, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = in_data;
          cnt_d   = shamt;
          arith_d = arith;
          if (shamt == '0) begin
            // Nothing to shift: publish the operand directly.
            state_d = DONE;
            out_d   = in_data;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q - SHAMT_W'(1);
        // Leave on the last step so the counter never wraps.
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
          out_d   = shifted;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
      out_q   <= out_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign out_data = out_q;

endmodule
